// File: rtl/shift_pkg.sv
// Shared types and defaults for the serial shifter: operation codes, FSM states
// and a helper that classifies the pass-through operations.
package shift_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_CNT_W = 3;

    typedef enum logic [2:0] {
        OP_PASS     = 3'd0,
        OP_LSL      = 3'd1,
        OP_ASL      = 3'd2,
        OP_LSR      = 3'd3,
        OP_ASR      = 3'd4,
        OP_ROL      = 3'd5,
        OP_ROR      = 3'd6,
        OP_PASS_ALT = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    function automatic logic is_pass(op_e op);
        return (op == OP_PASS) || (op == OP_PASS_ALT);
    endfunction

endpackage

// File: rtl/shift_step.sv
// Combinational single-position shift/rotate of a WIDTH-bit word; the op
// selects direction and what enters at the vacated end.
module shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] d,
    input  op_e              op,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] shl;
    logic [WIDTH-1:0] shr;
    logic             shl_fill;
    logic             shr_fill;

    // Bit entering at the LSB on left moves, and at the MSB on right moves.
    assign shl_fill = (op == OP_ROL) ? d[WIDTH-1] : 1'b0;
    assign shr_fill = (op == OP_ASR) ? d[WIDTH-1] :
                      (op == OP_ROR) ? d[0]       : 1'b0;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi = gi + 1) begin : g_bit
            if (gi == 0) begin : g_lsb
                assign shl[gi] = shl_fill;
            end else begin : g_shl
                assign shl[gi] = d[gi-1];
            end
            if (gi == WIDTH - 1) begin : g_msb
                assign shr[gi] = shr_fill;
            end else begin : g_shr
                assign shr[gi] = d[gi+1];
            end
        end
    endgenerate

    always_comb begin
        q = d;
        case (op)
            OP_LSL, OP_ASL, OP_ROL: q = shl;
            OP_LSR, OP_ASR, OP_ROR: q = shr;
            default:                q = d;
        endcase
    end

endmodule

// File: rtl/serial_shifter.sv
// Multi-cycle shifter: captures one request, applies one position per cycle,
// then presents the result until the consumer takes it.
module serial_shifter
    import shift_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] d_in,
    input  logic [2:0]       sel,
    input  logic [CNT_W-1:0] shift_count,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] d_out,
    output logic             busy
);

    state_e           state_reg;
    op_e              op_reg;
    logic [WIDTH-1:0] data_reg;
    logic [CNT_W-1:0] count_reg;
    logic             in_ready_reg;
    logic             out_valid_reg;
    logic             busy_reg;
    logic [WIDTH-1:0] step_next;

    shift_step #(.WIDTH(WIDTH)) u_step (
        .d  (data_reg),
        .op (op_reg),
        .q  (step_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            op_reg        <= OP_PASS;
            data_reg      <= '0;
            count_reg     <= '0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (in_valid) begin
                        data_reg     <= d_in;
                        op_reg       <= op_e'(sel);
                        count_reg    <= shift_count;
                        in_ready_reg <= 1'b0;
                        busy_reg     <= 1'b1;
                        // Nothing to shift: the captured operand is already the result.
                        if (shift_count == '0 || is_pass(op_e'(sel))) begin
                            state_reg     <= ST_DONE;
                            out_valid_reg <= 1'b1;
                        end else begin
                            state_reg <= ST_SHIFT;
                        end
                    end
                end
                ST_SHIFT: begin
                    data_reg  <= step_next;
                    count_reg <= count_reg - CNT_W'(1);
                    if (count_reg == CNT_W'(1)) begin
                        state_reg     <= ST_DONE;
                        out_valid_reg <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_reg     <= ST_IDLE;
                        out_valid_reg <= 1'b0;
                        busy_reg      <= 1'b0;
                        in_ready_reg  <= 1'b1;
                    end
                end
                default: begin
                    state_reg     <= ST_IDLE;
                    out_valid_reg <= 1'b0;
                    busy_reg      <= 1'b0;
                    in_ready_reg  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign busy      = busy_reg;
    assign d_out     = data_reg;

endmodule
